// File: rtl/pwm_decoder_if.sv
// rtl/pwm_decoder_if.sv - measurement result bundle published by the PWM decoder
interface pwm_decoder_if #(
    parameter int CNT_WIDTH = 16
);
    logic [CNT_WIDTH-1:0] period_out;
    logic [CNT_WIDTH-1:0] high_out;
    logic [7:0]           dc_out;
    logic                 res_ok_out;
    logic                 active_out;
    logic                 valid_out;

    modport master (
        output period_out, high_out, dc_out, res_ok_out, active_out, valid_out
    );
    modport slave (
        input  period_out, high_out, dc_out, res_ok_out, active_out, valid_out
    );
endinterface

// File: rtl/pwm_decoder.sv
// rtl/pwm_decoder.sv - measures PWM period/high time, decodes duty code, detects a stuck line
module pwm_decoder #(
    parameter int PWM_RESOLUTION = 256,
    parameter int CNT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          sig_in,
    pwm_decoder_if.master meas
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] RES_VAL = CNT_WIDTH'(PWM_RESOLUTION);
    localparam logic [CNT_WIDTH-1:0] TMO_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] DC_MAX  = CNT_WIDTH'(255);

    state_t               state;
    state_t               state_nxt;
    logic                 s1, s2, s3;
    logic                 rise, fall;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] hi_lat;
    logic                 fell;
    logic                 timeout;
    logic                 pub_rise;
    logic                 pub_stuck;
    logic [CNT_WIDTH-1:0] high_meas;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise      = s2 & ~s3;
    assign fall      = ~s2 & s3;
    assign timeout   = (cnt == TMO_VAL) & ~rise;
    assign high_meas = fell ? hi_lat : cnt;

    // cnt saturates so a dead line cannot wrap back onto the timeout value
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= CNT_ONE;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            hi_lat <= '0;
            fell   <= 1'b0;
        end else if (rise) begin
            fell <= 1'b0;
        end else if (fall) begin
            hi_lat <= cnt;
            fell   <= 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pub_rise  = 1'b0;
        pub_stuck = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = FIRST;
                end else if (timeout) begin
                    pub_stuck = 1'b1;
                end
            end
            FIRST, RUN: begin
                if (rise) begin
                    state_nxt = RUN;
                    pub_rise  = 1'b1;
                end else if (timeout) begin
                    state_nxt = IDLE;
                    pub_stuck = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // dc_out only follows measurements taken at the nominal resolution period
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            meas.period_out <= '0;
            meas.high_out   <= '0;
            meas.dc_out     <= 8'h00;
            meas.res_ok_out <= 1'b0;
            meas.active_out <= 1'b0;
            meas.valid_out  <= 1'b0;
        end else begin
            meas.valid_out <= pub_rise | pub_stuck;
            if (pub_rise) begin
                meas.period_out <= cnt;
                meas.high_out   <= high_meas;
                meas.res_ok_out <= (cnt == RES_VAL);
                meas.active_out <= 1'b1;
                if (cnt == RES_VAL) begin
                    meas.dc_out <= (high_meas > DC_MAX) ? 8'hFF : high_meas[7:0];
                end
            end else if (pub_stuck) begin
                meas.period_out <= '0;
                meas.high_out   <= '0;
                meas.res_ok_out <= 1'b0;
                meas.active_out <= 1'b0;
                meas.dc_out     <= s2 ? 8'hFF : 8'h00;
            end
        end
    end
endmodule

// File: doc/pwm_decoder.md
# pwm_decoder

Receive-side counterpart of the team's PWM generator. Measures an incoming PWM waveform (period and high time, in clock cycles), converts it back to an 8-bit duty-cycle code, and detects a stuck (gated-off or constant) line. It sits behind any PWM-driven path that must be read back, such as loopback self-test or an external PWM source feeding the design.

## Interface
- `PWM_RESOLUTION`, 256: expected period in cycles. `dc_out` is only decoded when the measured period equals this value.
- `CNT_WIDTH`, 16: width of the cycle counter, `period_out` and `high_out`.
- `TIMEOUT_CYCLES`, 1024: cycles without a rising edge before the line is declared stuck. Must be > `PWM_RESOLUTION` and < 2^`CNT_WIDTH`.
- `clk_in` input 1: the single clock.
- `rst_in` input 1: reset, asynchronous, active-low. All state clears while `rst_in`=0.
- `sig_in` input 1: PWM line. It may be asynchronous to `clk_in`.
- `period_out` output `CNT_WIDTH`: last measured period in cycles. 0 after reset or timeout.
- `high_out` output `CNT_WIDTH`: last measured high time in cycles. 0 after reset or timeout.
- `dc_out` output 8: decoded duty code. 0 after reset.
- `res_ok_out` output 1: the last measurement had `period_out == PWM_RESOLUTION`.
- `active_out` output 1: valid periodic signal present (state RUN).
- `valid_out` output 1: one-cycle pulse whenever the outputs update.

## Operation
- **Input conditioning**
  - `sig_in` passes through a 2-flop synchronizer (s1, s2) and then a history flop s3.
  - rise = s2 & ~s3.
  - fall = ~s2 & s3.
- **Counter `cnt`**
  - Loads 1 on the cycle after a rise.
  - Otherwise increments by 1 and saturates at all-ones.
- **Latched fall time**
  - On a fall, `hi_lat` <= `cnt` and flag `fell` <= 1.
  - `fell` clears on every rise.
- **States**
  - IDLE (reset state): no edge seen yet.
    - On rise → FIRST.
  - FIRST: one rise seen; the first partial period is discarded.
    - On rise → RUN and publish.
    - On timeout → IDLE and publish stuck.
  - RUN: periodic signal present.
    - On rise → publish and stay in RUN.
    - On timeout → IDLE and publish stuck.
  - Timeout condition: `cnt == TIMEOUT_CYCLES` with no rise in the same cycle.
- **Publish on rise**
  - `period_out` <= `cnt`.
  - `high_out` <= `fell ? hi_lat : cnt`. A fall in the same cycle as a rise cannot occur.
  - `res_ok_out` <= (`cnt == PWM_RESOLUTION`).
  - If `res_ok_out` is set: `dc_out` <= min(`high_out` value, 255). Otherwise `dc_out` holds its previous value.
  - `valid_out` pulses.
- **Publish stuck**
  - `period_out` <= 0, `high_out` <= 0, `res_ok_out` <= 0.
  - `dc_out` <= s2 ? 8'hFF : 8'h00.
  - `valid_out` pulses and `active_out` drops.
- **In IDLE**
  - `cnt` keeps running from reset.
  - A line held constant from reset publishes stuck once, when `cnt` reaches `TIMEOUT_CYCLES`.
  - It then holds, with `cnt` saturated, and does not re-pulse.
- **Mapping**
  - Matches the generator: duty code d produces a high time of d cycles.
  - d=0 gives a constant low line, which decodes via timeout as 0.
  - d=255 gives a high time of 255.
- **Reset mid-operation**
  - All flops clear immediately: state IDLE, `cnt` 0, all outputs 0.
  - The first measurement after release again takes two rises.

## Timing
- Let edge k be the first `clk_in` edge that samples `sig_in` high.
  - s2=1 and s3=0 after edge k+1, so rise is visible combinationally in that cycle.
  - Outputs update at edge k+2. `valid_out` is high from k+2 to k+3.
- Fall-to-`hi_lat` latency matches rise latency, so `high_out` is exact for clock-aligned input.
- Asynchronous input: measurements vary by ±1 cycle.
- `active_out` rises at the same edge as the first RUN publish.
- `active_out` falls at the edge that publishes stuck.
- Steady state: one `valid_out` per input period.
- Outputs are all registered.

## Test plan
- **Resolution-period measurement:** drive `sig_in` clock-aligned with period 256, high 64.
  - The second rise publishes `period_out`=256, `high_out`=64, `dc_out`=64, `res_ok_out`=1, `active_out`=1.
  - Each subsequent period gives `valid_out` exactly once.
- **Maximum duty:** drive period 256, high 255.
  - Required: `high_out`=255, `dc_out`=255.
  - Then switch to high 1: the next publish gives `dc_out`=1.
- **Wrong period:** drive period 200, high 50 while in RUN with `dc_out`=64.
  - Required: `period_out`=200, `high_out`=50, `res_ok_out`=0, `dc_out` stays 64.
- **Gate-off timeout:** in RUN, hold `sig_in` low.
  - Exactly 1024 cycles after the last `cnt` reload: `valid_out` pulses, `dc_out`=0, `period_out`=0, `active_out`=0, state IDLE.
  - No further `valid_out` pulses.
- **Constant high from reset:** hold `sig_in`=1 from reset release.
  - Required: a single stuck publish with `dc_out`=255, `active_out`=0.
  - Then restart the PWM: `active_out` returns only after the second rise.
- **Async reset mid-period:** assert `rst_in`=0 between edges while in RUN.
  - All outputs go to 0 without waiting for a clock.
  - After release, the first `valid_out` comes on the second rise.
